// File: rtl/serializer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serializer_ctrl
// Function : Sequencer for the POY-row output serializer. Accepts a finished
//            tile from the MAC array, drives the serializer load strobe and
//            shift select, presents one row per valid/ready handshake and
//            counts tiles to flag end of frame.
// Revision : 1.0 - initial release
// ============================================================================
module serializer_ctrl #(
    parameter int POX        = 3,
    parameter int POY        = 3,
    parameter int TILE_CNT_W = 16,
    localparam int ROW_W     = (POY > 1) ? $clog2(POY) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mac_valid,
    output logic                  mac_ready,
    output logic                  ser_load,
    output logic                  ser_shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_W-1:0]      out_row_idx,
    output logic                  out_last_row,
    input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
    output logic                  tile_done,
    output logic                  frame_done
);

    // POX only sets datapath widths elsewhere; reject nonsensical sizes early.
    if (POX < 1) begin : g_pox_check
        $error("serializer_ctrl: POX must be at least 1");
    end
    if (POY < 1) begin : g_poy_check
        $error("serializer_ctrl: POY must be at least 1");
    end

    localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(POY - 1);
    localparam logic [ROW_W-1:0]      ROW_ONE  = ROW_W'(1);
    localparam logic [TILE_CNT_W-1:0] TILE_ONE = TILE_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                state;
    logic [ROW_W-1:0]      row_cnt;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic [TILE_CNT_W-1:0] cfg_lat;

    logic in_emit;
    logic is_last;
    logic row_hs;
    logic last_hs;
    logic accept;
    logic frame_end;
    logic [TILE_CNT_W-1:0] cfg_sel;

    // Handshake decode: everything below is a function of state and inputs.
    always_comb begin
        in_emit   = (state == EMIT);
        is_last   = (row_cnt == LAST_ROW);
        row_hs    = in_emit & out_ready;
        last_hs   = row_hs & is_last;
        // A new tile may enter while the last row of the previous one leaves.
        mac_ready = (state == IDLE) | last_hs;
        accept    = mac_valid & mac_ready;
        frame_end = (tile_cnt == (cfg_lat - TILE_ONE));
        // A zero tile count would never end a frame; treat it as one.
        cfg_sel   = (cfg_num_tiles == '0) ? TILE_ONE : cfg_num_tiles;
    end

    // Serializer strobes and row presentation derived from the state registers.
    always_comb begin
        ser_load     = accept;
        ser_shift    = row_hs & ~is_last;
        out_valid    = in_emit;
        out_row_idx  = row_cnt;
        out_last_row = in_emit & is_last;
        tile_done    = last_hs;
        frame_done   = last_hs & frame_end;
    end

    // Tile sequencing FSM with row and tile counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            tile_cnt <= '0;
            cfg_lat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= FILL;
                        row_cnt <= '0;
                        cfg_lat <= cfg_sel;
                    end
                end
                // Serializer register holds the tile, its output does not yet.
                FILL: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (row_hs) begin
                        if (!is_last) begin
                            row_cnt <= row_cnt + ROW_ONE;
                            state   <= GAP;
                        end else begin
                            row_cnt  <= '0;
                            tile_cnt <= frame_end ? '0 : (tile_cnt + TILE_ONE);
                            if (accept) begin
                                state   <= FILL;
                                cfg_lat <= cfg_sel;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                // Serializer output still shows the previous row for one cycle.
                GAP: begin
                    state <= EMIT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serializer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serializer_ctrl
// Function : Directed self-checking bench for serializer_ctrl (POY=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serializer_ctrl;

    localparam int POX = 3;
    localparam int POY = 3;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mac_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [TW-1:0] cfg_num_tiles = 16'd1;
    logic          mac_ready;
    logic          ser_load;
    logic          ser_shift;
    logic          out_valid;
    logic [1:0]    out_row_idx;
    logic          out_last_row;
    logic          tile_done;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serializer_ctrl #(
        .POX        (POX),
        .POY        (POY),
        .TILE_CNT_W (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mac_valid     (mac_valid),
        .mac_ready     (mac_ready),
        .ser_load      (ser_load),
        .ser_shift     (ser_shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row_idx   (out_row_idx),
        .out_last_row  (out_last_row),
        .cfg_num_tiles (cfg_num_tiles),
        .tile_done     (tile_done),
        .frame_done    (frame_done)
    );

    // Hold reset for two edges; returns just after the edge that releases it.
    task automatic do_reset();
        rst       = 1'b0;
        mac_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        do_reset();
        @(negedge clk);
        got = {mac_ready, ser_load, ser_shift, out_valid, tile_done, frame_done,
               out_row_idx};
        checks++;
        if (got !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got, 8'b1000_0000);
        end
        checks++;
        if (out_last_row !== 1'b0) begin
            failures++;
            $display("FAIL reset_last_row got=%b exp=0", out_last_row);
        end
        @(posedge clk);
        #1;
    endtask

    // Single tile, out_ready held high: rows at L+2, L+4, L+6.
    task automatic test_single_tile(input bit with_reset);
        logic [7:0] e_ready, e_load, e_shift, e_ov, e_td;
        logic [5:0] got, exp;
        int         e_idx [8];
        if (with_reset) do_reset();
        cfg_num_tiles = 16'd1;
        out_ready = 1'b1;
        e_ready = 8'b1100_0001;
        e_load  = 8'b0000_0001;
        e_shift = 8'b0001_0100;
        e_ov    = 8'b0101_0100;
        e_td    = 8'b0100_0000;
        e_idx   = '{-1, -1, 0, -1, 1, -1, 2, -1};
        for (int c = 0; c < 8; c++) begin
            mac_valid = (c == 0);
            @(negedge clk);
            got = {mac_ready, ser_load, ser_shift, out_valid, tile_done, frame_done};
            exp = {e_ready[c], e_load[c], e_shift[c], e_ov[c], e_td[c], e_td[c]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single_tile c%0d ctl got=%b exp=%b (ready,load,shift,valid,tile_done,frame_done)",
                         c, got, exp);
            end
            if (e_idx[c] >= 0) begin
                checks++;
                if ({out_row_idx, out_last_row} !== {2'(e_idx[c]), (e_idx[c] == 2)}) begin
                    failures++;
                    $display("FAIL single_tile c%0d row got=%0d/%b exp=%0d/%b",
                             c, out_row_idx, out_last_row, e_idx[c], (e_idx[c] == 2));
                end
            end
            @(posedge clk);
            #1;
        end
        mac_valid = 1'b0;
    endtask

    // Row 1 is stalled for five cycles by out_ready low.
    task automatic test_stall();
        logic [15:0] e_ready, e_load, e_shift, e_ov, e_td, ordy;
        logic [5:0]  got, exp;
        int          e_idx [13];
        do_reset();
        cfg_num_tiles = 16'd1;
        ordy    = 16'b1111_1110_0000_1111;
        e_ready = 16'b0001_1000_0000_0001;
        e_load  = 16'b0000_0000_0000_0001;
        e_shift = 16'b0000_0010_0000_0100;
        e_ov    = 16'b0000_1011_1111_0100;
        e_td    = 16'b0000_1000_0000_0000;
        e_idx   = '{-1, -1, 0, -1, 1, 1, 1, 1, 1, 1, -1, 2, -1};
        for (int c = 0; c < 13; c++) begin
            mac_valid = (c == 0);
            out_ready = ordy[c];
            @(negedge clk);
            got = {mac_ready, ser_load, ser_shift, out_valid, tile_done, frame_done};
            exp = {e_ready[c], e_load[c], e_shift[c], e_ov[c], e_td[c], e_td[c]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall c%0d ctl got=%b exp=%b (ready,load,shift,valid,tile_done,frame_done)",
                         c, got, exp);
            end
            if (e_idx[c] >= 0) begin
                checks++;
                if ({out_row_idx, out_last_row} !== {2'(e_idx[c]), (e_idx[c] == 2)}) begin
                    failures++;
                    $display("FAIL stall c%0d row got=%0d/%b exp=%0d/%b",
                             c, out_row_idx, out_last_row, e_idx[c], (e_idx[c] == 2));
                end
            end
            @(posedge clk);
            #1;
        end
        mac_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    // mac_valid held high: next tile loads in the last-row accept cycle.
    task automatic test_back_to_back();
        logic [15:0] e_ready, e_shift, e_ov, e_td;
        logic [5:0]  got, exp;
        int          e_idx [14];
        do_reset();
        cfg_num_tiles = 16'd1;
        out_ready = 1'b1;
        mac_valid = 1'b1;
        e_ready = 16'h1041;
        e_shift = 16'h0514;
        e_ov    = 16'h1554;
        e_td    = 16'h1040;
        e_idx   = '{-1, -1, 0, -1, 1, -1, 2, -1, 0, -1, 1, -1, 2, -1};
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            got = {mac_ready, ser_load, ser_shift, out_valid, tile_done, frame_done};
            exp = {e_ready[c], e_ready[c], e_shift[c], e_ov[c], e_td[c], e_td[c]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back c%0d ctl got=%b exp=%b (ready,load,shift,valid,tile_done,frame_done)",
                         c, got, exp);
            end
            if (e_idx[c] >= 0) begin
                checks++;
                if ({out_row_idx, out_last_row} !== {2'(e_idx[c]), (e_idx[c] == 2)}) begin
                    failures++;
                    $display("FAIL back_to_back c%0d row got=%0d/%b exp=%0d/%b",
                             c, out_row_idx, out_last_row, e_idx[c], (e_idx[c] == 2));
                end
            end
            @(posedge clk);
            #1;
        end
        mac_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    // cfg_num_tiles=2 over six tiles: frame_done on tiles 2, 4, 6.
    task automatic test_frame_count();
        int         loads, tiles, cyc, stray;
        logic [5:0] fpat;
        do_reset();
        cfg_num_tiles = 16'd2;
        out_ready = 1'b1;
        loads = 0; tiles = 0; cyc = 0; stray = 0; fpat = '0;
        while (tiles < 6 && cyc < 200) begin
            mac_valid = (loads < 6);
            @(negedge clk);
            if (ser_load) loads++;
            if (tile_done) begin
                fpat[tiles] = frame_done;
                tiles++;
            end else if (frame_done) begin
                stray++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        mac_valid = 1'b0;
        checks++;
        if (tiles != 6) begin
            failures++;
            $display("FAIL frame_count_tiles got=%0d exp=6 (cycle budget)", tiles);
        end
        checks++;
        if (fpat !== 6'b101010) begin
            failures++;
            $display("FAIL frame_count_pattern got=%b exp=%b", fpat, 6'b101010);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL frame_count_stray got=%0d exp=0", stray);
        end
    endtask

    // cfg_num_tiles=0 behaves as one tile per frame.
    task automatic test_cfg_zero();
        int         loads, tiles, cyc;
        logic [2:0] fpat;
        do_reset();
        cfg_num_tiles = 16'd0;
        out_ready = 1'b1;
        loads = 0; tiles = 0; cyc = 0; fpat = '0;
        while (tiles < 3 && cyc < 200) begin
            mac_valid = (loads < 3);
            @(negedge clk);
            if (ser_load) loads++;
            if (tile_done) begin
                fpat[tiles] = frame_done;
                tiles++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        mac_valid = 1'b0;
        checks++;
        if (tiles != 3) begin
            failures++;
            $display("FAIL cfg_zero_tiles got=%0d exp=3 (cycle budget)", tiles);
        end
        checks++;
        if (fpat !== 3'b111) begin
            failures++;
            $display("FAIL cfg_zero_pattern got=%b exp=%b", fpat, 3'b111);
        end
    endtask

    // Reset during the GAP before row 1 discards the tile silently.
    task automatic test_reset_mid();
        do_reset();
        cfg_num_tiles = 16'd1;
        out_ready = 1'b1;
        mac_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ser_load !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_load got=%b exp=1", ser_load);
        end
        @(posedge clk);
        #1;
        mac_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_row_idx, ser_shift} !== 4'b1001) begin
            failures++;
            $display("FAIL reset_mid_row0 got=%b exp=%b", {out_valid, out_row_idx, ser_shift}, 4'b1001);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, tile_done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_gap got=%b exp=00", {out_valid, tile_done});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({mac_ready, out_valid, tile_done, frame_done} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_mid_idle c%0d got=%b exp=1000 (ready,valid,tile_done,frame_done)",
                         c, {mac_ready, out_valid, tile_done, frame_done});
            end
            @(posedge clk);
            #1;
        end
        test_single_tile(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_tile(1'b1);
        test_stall();
        test_back_to_back();
        test_frame_count();
        test_cfg_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
